// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control path.
// Holds the opcode/funct encodings, FSM state codes, PC/writeback mux
// selects, ALU source and ALU operation encodings, and the decoded
// instruction-class bundle that instr_decode hands to the FSM.
package multicycle_control_pkg;

  // Opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // FSM states
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  // PC source select
  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  // Register-file writeback select
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  // ALU second-operand select
  localparam logic [1:0] ALU_SRC_REG             = 2'd0;
  localparam logic [1:0] ALU_SRC_SEXT_IMM16      = 2'd1;
  localparam logic [1:0] ALU_SRC_ZEXT_IMM16      = 2'd2;
  localparam logic [1:0] ALU_SRC_SEXT_IMM16_SHL2 = 2'd3;

  // ALU operations
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  // Instruction class as seen by the sequencing FSM
  typedef struct packed {
    logic       is_lw;
    logic       is_sw;
    logic       is_bne;
    logic       is_j;
    logic       is_jal;
    logic       is_jr;
    logic       illegal;
    logic [2:0] alu_op;
    logic [1:0] alu_src;
  } dec_class_t;

endpackage

// File: rtl/multicycle_control_instr_decode.sv
// instr_decode: purely combinational field and class decode of a MIPS word.
// Ports:
//   instruction        - 32-bit instruction word
//   cls                - instruction class + EXEC-phase ALU controls
//   addr_a/addr_b      - source register addresses (rt/rt for shifts, rs/rt otherwise)
//   addr_in            - destination register (rd, rt, or LINK_REG for jal)
//   shamt/imm16/addr26 - raw instruction fields (shamt zero unless a shift)
//   is_jump/is_branch  - class flags
module instr_decode
  import multicycle_control_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31
) (
  input  logic [31:0]           instruction,
  output dec_class_t            cls,
  output logic [REG_ADDR_W-1:0] addr_a,
  output logic [REG_ADDR_W-1:0] addr_b,
  output logic [REG_ADDR_W-1:0] addr_in,
  output logic [4:0]            shamt,
  output logic [15:0]           imm16,
  output logic [25:0]           addr26,
  output logic                  is_jump,
  output logic                  is_branch
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_shift;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign imm16  = instruction[15:0];
  assign addr26 = instruction[25:0];

  always_comb begin
    cls       = '0;
    is_shift  = 1'b0;
    is_branch = 1'b0;
    cls.alu_op  = OP_ADD;
    cls.alu_src = ALU_SRC_REG;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FUNCT_ADD: cls.alu_op = OP_ADD;
          FUNCT_SUB: cls.alu_op = OP_SUB;
          FUNCT_AND: cls.alu_op = OP_AND;
          FUNCT_OR:  cls.alu_op = OP_OR;
          FUNCT_NOR: cls.alu_op = OP_NOR;
          FUNCT_SLT: cls.alu_op = OP_SLT;
          FUNCT_SLL: begin cls.alu_op = OP_SLL; is_shift = 1'b1; end
          FUNCT_SRL: begin cls.alu_op = OP_SRL; is_shift = 1'b1; end
          FUNCT_JR:  cls.is_jr = 1'b1;
          default:   cls.illegal = 1'b1;
        endcase
      end
      OPC_ADDI: cls.alu_src = ALU_SRC_SEXT_IMM16;
      OPC_ANDI: begin cls.alu_op = OP_AND; cls.alu_src = ALU_SRC_ZEXT_IMM16; end
      OPC_ORI:  begin cls.alu_op = OP_OR;  cls.alu_src = ALU_SRC_ZEXT_IMM16; end
      OPC_LW:   begin cls.is_lw = 1'b1; cls.alu_src = ALU_SRC_SEXT_IMM16; end
      OPC_SW:   begin cls.is_sw = 1'b1; cls.alu_src = ALU_SRC_SEXT_IMM16; end
      OPC_BEQ:  begin cls.alu_op = OP_SUB; is_branch = 1'b1; end
      OPC_BNE:  begin cls.alu_op = OP_SUB; is_branch = 1'b1; cls.is_bne = 1'b1; end
      OPC_J:    cls.is_j = 1'b1;
      OPC_JAL:  cls.is_jal = 1'b1;
      default:  cls.illegal = 1'b1;
    endcase
  end

  assign is_jump = cls.is_j | cls.is_jal | cls.is_jr;

  // Shifts take their operand from rt; the 5-bit fields are resized to the
  // register-file address width (zero-extend or truncate).
  assign addr_a  = is_shift ? REG_ADDR_W'(instruction[20:16])
                            : REG_ADDR_W'(instruction[25:21]);
  assign addr_b  = REG_ADDR_W'(instruction[20:16]);
  assign addr_in = cls.is_jal               ? REG_ADDR_W'(LINK_REG) :
                   (opcode == OPC_RTYPE)    ? REG_ADDR_W'(instruction[15:11]) :
                                              REG_ADDR_W'(instruction[20:16]);
  assign shamt   = is_shift ? instruction[10:6] : 5'd0;

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the multicycle
// MIPS datapath. Wraps instr_decode and drives datapath enables, ALU
// controls and a req/ready memory handshake with a bounded wait.
// Ports:
//   clk, rst_n               - clock, async active-low reset
//   instruction, zero        - IR contents, ALU zero flag
//   mem_ready / mem_req/mem_we/mem_addr_sel - memory handshake
//   ir_write, pc_write, pc_src, reg_write, wb_sel - datapath enables/selects
//   alu_src, alu_op          - ALU controls
//   addr_a/addr_b/addr_in, shamt, imm16, addr26 - decoded fields
//   is_jump, is_branch, illegal, mem_timeout, state - flags and debug
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instruction,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_addr_sel,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic [1:0]            alu_src,
  output logic [2:0]            alu_op,
  output logic [REG_ADDR_W-1:0] addr_a,
  output logic [REG_ADDR_W-1:0] addr_b,
  output logic [REG_ADDR_W-1:0] addr_in,
  output logic [4:0]            shamt,
  output logic [15:0]           imm16,
  output logic [25:0]           addr26,
  output logic                  is_jump,
  output logic                  is_branch,
  output logic                  illegal,
  output logic                  mem_timeout,
  output logic [2:0]            state
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  dec_class_t       cls;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             timeout_hit;
  logic             mem_req_c, ir_write_c, pc_write_c, reg_write_c, illegal_c;

  instr_decode #(
    .REG_ADDR_W (REG_ADDR_W),
    .LINK_REG   (LINK_REG)
  ) u_decode (
    .instruction (instruction),
    .cls         (cls),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .addr_in     (addr_in),
    .shamt       (shamt),
    .imm16       (imm16),
    .addr26      (addr26),
    .is_jump     (is_jump),
    .is_branch   (is_branch)
  );

  // The timeout cycle itself carries no request, so a late mem_ready on
  // that cycle is ignored and the access is abandoned cleanly.
  assign timeout_hit = (MAX_WAIT != 0) && (wait_q == CNT_W'(MAX_WAIT));

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src       = PC_SRC_PC4;
    reg_write_c  = 1'b0;
    wb_sel       = WB_SEL_ALU;
    alu_src      = ALU_SRC_REG;
    alu_op       = OP_ADD;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!timeout_hit) begin
          mem_req_c = 1'b1;
          if (mem_ready) begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            state_d    = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        // ALU forms the branch target speculatively while decoding
        alu_src = ALU_SRC_SEXT_IMM16_SHL2;
        alu_op  = OP_ADD;
        state_d = S_FETCH;
        if (cls.illegal) begin
          illegal_c = 1'b1;
        end else if (cls.is_j || cls.is_jal) begin
          pc_write_c = 1'b1;
          pc_src     = PC_SRC_JUMP;
          if (cls.is_jal) begin
            reg_write_c = 1'b1;
            wb_sel      = WB_SEL_LINK;
          end
        end else if (cls.is_jr) begin
          pc_write_c = 1'b1;
          pc_src     = PC_SRC_REG;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op  = cls.alu_op;
        alu_src = cls.alu_src;
        if (is_branch) begin
          pc_write_c = zero ^ cls.is_bne;
          pc_src     = PC_SRC_BRANCH;
          state_d    = S_FETCH;
        end else if (cls.is_lw || cls.is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_op       = cls.alu_op;
        alu_src      = cls.alu_src;
        mem_addr_sel = 1'b1;
        if (timeout_hit) begin
          state_d = S_FETCH;
        end else begin
          mem_req_c = 1'b1;
          mem_we    = cls.is_sw;
          if (mem_ready) state_d = cls.is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        alu_op      = cls.alu_op;
        alu_src     = cls.alu_src;
        reg_write_c = 1'b1;
        wb_sel      = cls.is_lw ? WB_SEL_MEM : WB_SEL_ALU;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if ((MAX_WAIT == 0) || timeout_hit || mem_ready || (state_d != state_q))
      wait_d = '0;
    else if (mem_req_c)
      wait_d = wait_q + CNT_W'(1);
    else
      wait_d = wait_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Enables are gated by rst_n so they drop in the very cycle reset asserts,
  // not at the next clock edge.
  assign mem_req     = mem_req_c   & rst_n;
  assign ir_write    = ir_write_c  & rst_n;
  assign pc_write    = pc_write_c  & rst_n;
  assign reg_write   = reg_write_c & rst_n;
  assign illegal     = illegal_c   & rst_n;
  assign mem_timeout = timeout_hit & rst_n;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (MAX_WAIT = 4).
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write;
  logic [1:0]  pc_src, wb_sel, alu_src;
  logic [2:0]  alu_op, state;
  logic [4:0]  addr_a, addr_b, addr_in, shamt;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic        is_jump, is_branch, illegal, mem_timeout;

  int checks = 0;
  int errors = 0;

  multicycle_control #(
    .REG_ADDR_W (5),
    .LINK_REG   (31),
    .MAX_WAIT   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .addr_in      (addr_in),
    .shamt        (shamt),
    .imm16        (imm16),
    .addr26       (addr26),
    .is_jump      (is_jump),
    .is_branch    (is_branch),
    .illegal      (illegal),
    .mem_timeout  (mem_timeout),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // One conditional branch: FETCH, DECODE, EXEC, starting at a FETCH cycle.
  task automatic run_branch(input string tag, input logic [31:0] ins,
                            input logic z, input logic exp_pw);
    @(negedge clk); instruction = ins; zero = z; mem_ready = 1'b1; #1;
    chk({tag, "_fetch_state"}, state, 0);
    @(negedge clk); #1;
    chk({tag, "_dec_state"}, state, 1);
    chk({tag, "_is_branch"}, is_branch, 1);
    @(negedge clk); #1;
    chk({tag, "_exec_state"}, state, 2);
    chk({tag, "_exec_alu_op"}, alu_op, 1);
    chk({tag, "_exec_pc_write"}, pc_write, exp_pw);
    chk({tag, "_exec_pc_src"}, pc_src, 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; instruction = 32'h0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    instruction = 32'h2010FEFE; #1;
    chk("rst_state", state, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_mem_timeout", mem_timeout, 0);
    chk("rst_addr_in", addr_in, 16);
    chk("rst_imm16", imm16, 16'hFEFE);

    // addi $s0,$zero,0xFEFE with zero-wait memory
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; #1;
    chk("addi_fetch_state", state, 0);
    chk("addi_fetch_mem_req", mem_req, 1);
    chk("addi_fetch_ir_write", ir_write, 1);
    chk("addi_fetch_pc_write", pc_write, 1);
    chk("addi_fetch_pc_src", pc_src, 0);
    chk("addi_fetch_reg_write", reg_write, 0);
    @(negedge clk); #1;
    chk("addi_dec_state", state, 1);
    chk("addi_dec_alu_src", alu_src, 3);
    chk("addi_dec_reg_write", reg_write, 0);
    @(negedge clk); #1;
    chk("addi_exec_state", state, 2);
    chk("addi_exec_alu_src", alu_src, 1);
    chk("addi_exec_alu_op", alu_op, 0);
    chk("addi_exec_reg_write", reg_write, 0);
    @(negedge clk); #1;
    chk("addi_wb_state", state, 4);
    chk("addi_wb_reg_write", reg_write, 1);
    chk("addi_wb_sel", wb_sel, 0);
    chk("addi_wb_addr_in", addr_in, 16);

    // lw $t0,4($s0) with three wait cycles in MEM
    @(negedge clk); instruction = 32'h8E080004; #1;
    chk("lw_fetch_state", state, 0);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("lw_dec_state", state, 1);
    @(negedge clk); #1;
    chk("lw_exec_state", state, 2);
    chk("lw_exec_alu_src", alu_src, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("lw_mem_wait_state", state, 3);
      chk("lw_mem_wait_req", mem_req, 1);
      chk("lw_mem_wait_we", mem_we, 0);
      chk("lw_mem_wait_addr_sel", mem_addr_sel, 1);
      chk("lw_mem_wait_timeout", mem_timeout, 0);
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("lw_mem_ready_state", state, 3);
    chk("lw_mem_ready_req", mem_req, 1);
    @(negedge clk); #1;
    chk("lw_wb_state", state, 4);
    chk("lw_wb_reg_write", reg_write, 1);
    chk("lw_wb_sel", wb_sel, 1);
    chk("lw_wb_addr_in", addr_in, 8);

    run_branch("beq_z1", 32'h1120FFFD, 1'b1, 1'b1);
    run_branch("beq_z0", 32'h1120FFFD, 1'b0, 1'b0);
    run_branch("bne_z1", 32'h1520FFFD, 1'b1, 1'b0);
    run_branch("bne_z0", 32'h1520FFFD, 1'b0, 1'b1);

    // jal 0x0000100
    @(negedge clk); instruction = 32'h0C000100; #1;
    chk("jal_fetch_state", state, 0);
    @(negedge clk); #1;
    chk("jal_dec_state", state, 1);
    chk("jal_pc_write", pc_write, 1);
    chk("jal_pc_src", pc_src, 2);
    chk("jal_reg_write", reg_write, 1);
    chk("jal_wb_sel", wb_sel, 2);
    chk("jal_addr_in", addr_in, 31);
    chk("jal_is_jump", is_jump, 1);
    chk("jal_addr26", addr26, 26'h100);

    // illegal opcode 0x3F
    @(negedge clk); instruction = 32'hFC000000; #1;
    chk("jal_next_fetch_state", state, 0);
    @(negedge clk); #1;
    chk("ill_dec_state", state, 1);
    chk("ill_pulse", illegal, 1);
    chk("ill_pc_write", pc_write, 0);
    chk("ill_reg_write", reg_write, 0);

    // FETCH with mem_ready held low: timeout after 4 waiting cycles
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("to_fetch_state", state, 0);
    chk("to_ill_cleared", illegal, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk("to_wait_req", mem_req, 1);
      chk("to_wait_ir_write", ir_write, 0);
      chk("to_wait_timeout", mem_timeout, 0);
    end
    @(negedge clk); #1;
    chk("to_pulse", mem_timeout, 1);
    chk("to_pulse_req", mem_req, 0);
    chk("to_pulse_ir_write", ir_write, 0);
    chk("to_pulse_pc_write", pc_write, 0);
    chk("to_pulse_state", state, 0);

    // refetch succeeds: sw $t0,4($s0), then reset asserted mid-MEM
    @(negedge clk); instruction = 32'hAE080004; mem_ready = 1'b1; #1;
    chk("refetch_state", state, 0);
    chk("refetch_timeout", mem_timeout, 0);
    chk("refetch_req", mem_req, 1);
    chk("refetch_ir_write", ir_write, 1);
    @(negedge clk); #1;
    chk("sw_dec_state", state, 1);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("sw_exec_state", state, 2);
    @(negedge clk); #1;
    chk("sw_mem_state", state, 3);
    chk("sw_mem_req", mem_req, 1);
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_addr_sel", mem_addr_sel, 1);
    #2; rst_n = 1'b0; #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_state", state, 0);
    chk("midrst_reg_write", reg_write, 0);
    @(negedge clk); #1;
    chk("midrst_hold_req", mem_req, 0);
    chk("midrst_hold_pc_write", pc_write, 0);
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; #1;
    chk("postrst_state", state, 0);
    chk("postrst_req", mem_req, 1);
    chk("postrst_ir_write", ir_write, 1);

    // field decode of sll $t0,$t1,3
    instruction = 32'h000940C0; #1;
    chk("sll_addr_a", addr_a, 9);
    chk("sll_addr_in", addr_in, 8);
    chk("sll_shamt", shamt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
